// File: rtl/dfdd_pkg.sv
// rtl/dfdd_pkg.sv - shared types and constants for the vertical fp16 downsampler
//
// Provides the pixel word width derivation, the 16-bit coordinate type and
// fp_const(), which builds a power-of-two fp word (sign 0, fraction 0) whose
// exponent is bias + exp_offset.
package dfdd_pkg;

    typedef logic [15:0] coord_t;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // Result is zero-extended to 32 bits; callers keep the low fp_width bits.
    function automatic logic [31:0] fp_const(input int exp_offset,
                                             input int exp_w = 5,
                                             input int frac_w = 10);
        int bias;
        bias = (1 << (exp_w - 1)) - 1;
        return $unsigned((bias + exp_offset) << frac_w);
    endfunction

endpackage

// File: rtl/downsampler_v_window_fp16_if.sv
// rtl/downsampler_v_window_fp16_if.sv - pixel-in / window-out bundle for the vertical downsampler
//
// Inputs : data_i, col_i, row_i, valid_i (raster pixel stream, no backpressure)
// Outputs: window_o[0..2] (above/centre/below), kernel_o[0..2], col_o, row_o,
//          valid_o, err_o
// master: the stream source and window sink; slave: the downsampler.
interface downsampler_v_window_fp16_if #(
    parameter int EXP_WIDTH  = 5,
    parameter int FRAC_WIDTH = 10
);
    localparam int FP_WIDTH_REG = dfdd_pkg::fp_width(EXP_WIDTH, FRAC_WIDTH);

    logic [FP_WIDTH_REG-1:0]       data_i;
    dfdd_pkg::coord_t              col_i;
    dfdd_pkg::coord_t              row_i;
    logic                          valid_i;
    logic [2:0][FP_WIDTH_REG-1:0]  window_o;
    logic [2:0][FP_WIDTH_REG-1:0]  kernel_o;
    dfdd_pkg::coord_t              col_o;
    dfdd_pkg::coord_t              row_o;
    logic                          valid_o;
    logic                          err_o;

    modport master (
        output data_i, col_i, row_i, valid_i,
        input  window_o, kernel_o, col_o, row_o, valid_o, err_o
    );

    modport slave (
        input  data_i, col_i, row_i, valid_i,
        output window_o, kernel_o, col_o, row_o, valid_o, err_o
    );

endinterface

// File: rtl/downsampler_v_window_fp16_line_buffer_rbw.sv
// rtl/downsampler_v_window_fp16_line_buffer_rbw.sv - one-line RAM, sync read, read-before-write
//
// Ports: clk_i, we (write enable), waddr, wdata, raddr, rdata (registered).
// A read and a write to the same address on one edge return the old word.
// Contents are not reset.
module line_buffer_rbw #(
    parameter int DEPTH      = 640,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/downsampler_v_window_fp16.sv
// rtl/downsampler_v_window_fp16.sv - vertical 2x decimator emitting 3x1 windows on even centre rows
//
// Ports: clk_i, rst_i (async, active-high), bus (slave modport):
//   data_i/col_i/row_i/valid_i in; window_o/kernel_o/col_o/row_o/valid_o/err_o out.
// Two-cycle latency: RAM read stage, then output register.
// Optional macro DOWNSAMPLER_V_PROTOCOL_CHECK_EN enables the sticky err_o checker;
// otherwise err_o is tied low.
module downsampler_v_window_fp16
    import dfdd_pkg::*;
#(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    downsampler_v_window_fp16_if.slave  bus
);

    localparam int FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH);
    localparam int AW           = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    typedef logic [FP_WIDTH_REG-1:0] fp_t;
    typedef logic [AW-1:0]           addr_t;

    localparam logic [31:0] K_EDGE_RAW   = fp_const(-2, EXP_WIDTH, FRAC_WIDTH);
    localparam logic [31:0] K_CENTRE_RAW = fp_const(-1, EXP_WIDTH, FRAC_WIDTH);
    localparam fp_t         K_EDGE       = K_EDGE_RAW[FP_WIDTH_REG-1:0];
    localparam fp_t         K_CENTRE     = K_CENTRE_RAW[FP_WIDTH_REG-1:0];

    if (IMAGE_HEIGHT % 2 != 0) begin : g_bad_height
        $error("IMAGE_HEIGHT must be even");
    end
    // LB2 is written one cycle after LB1 (it needs LB1's registered read data),
    // so the same column must not be revisited on the very next cycle.
    if (IMAGE_WIDTH < 2) begin : g_bad_width
        $error("IMAGE_WIDTH must be at least 2");
    end

    logic  accept;
    addr_t in_addr;
    fp_t   lb1_rd;
    fp_t   lb2_rd;

    assign accept  = bus.valid_i && !rst_i && (bus.col_i < coord_t'(IMAGE_WIDTH));
    assign in_addr = bus.col_i[AW-1:0];

    logic   s1_wr;
    logic   s1_emit;
    logic   s1_top;
    addr_t  s1_addr;
    fp_t    s1_data;
    coord_t s1_col;
    coord_t s1_row;

    line_buffer_rbw #(.DEPTH(IMAGE_WIDTH), .WIDTH(FP_WIDTH_REG), .ADDR_WIDTH(AW)) u_lb1 (
        .clk_i (clk_i),
        .we    (accept),
        .waddr (in_addr),
        .wdata (bus.data_i),
        .raddr (in_addr),
        .rdata (lb1_rd)
    );

    // LB2 takes the old LB1 word once it has been read out.
    line_buffer_rbw #(.DEPTH(IMAGE_WIDTH), .WIDTH(FP_WIDTH_REG), .ADDR_WIDTH(AW)) u_lb2 (
        .clk_i (clk_i),
        .we    (s1_wr),
        .waddr (s1_addr),
        .wdata (lb1_rd),
        .raddr (in_addr),
        .rdata (lb2_rd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_wr   <= 1'b0;
            s1_emit <= 1'b0;
            s1_top  <= 1'b0;
            s1_addr <= '0;
            s1_data <= '0;
            s1_col  <= '0;
            s1_row  <= '0;
        end else begin
            s1_wr   <= accept;
            s1_emit <= accept && bus.row_i[0];
            if (accept) begin
                s1_addr <= in_addr;
                s1_data <= bus.data_i;
                s1_col  <= bus.col_i;
                s1_row  <= bus.row_i;
                s1_top  <= (bus.row_i == 16'd1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.valid_o  <= 1'b0;
            bus.window_o <= '0;
            bus.col_o    <= '0;
            bus.row_o    <= '0;
        end else begin
            bus.valid_o <= s1_emit;
            if (s1_emit) begin
                // Row 1 is centred on row 0, which has no row above: replicate it.
                bus.window_o[0] <= s1_top ? lb1_rd : lb2_rd;
                bus.window_o[1] <= lb1_rd;
                bus.window_o[2] <= s1_data;
                bus.col_o       <= s1_col;
                bus.row_o       <= s1_row >> 1;
            end
        end
    end

    assign bus.kernel_o = {K_EDGE, K_CENTRE, K_EDGE};

`ifdef DOWNSAMPLER_V_PROTOCOL_CHECK_EN
    coord_t prev_col;
    coord_t prev_row;
    logic   have_prev;
    logic   violation;
    logic   err_q;

    always_comb begin
        violation = 1'b0;
        if (bus.valid_i) begin
            if (bus.col_i >= coord_t'(IMAGE_WIDTH) || bus.row_i >= coord_t'(IMAGE_HEIGHT)) begin
                violation = 1'b1;
            end
            if (have_prev) begin
                if (bus.row_i == prev_row) begin
                    if (bus.col_i != prev_col + 16'd1) begin
                        violation = 1'b1;
                    end
                end else begin
                    if (prev_col != coord_t'(IMAGE_WIDTH - 1)) begin
                        violation = 1'b1;
                    end
                    if (!((bus.row_i == prev_row + 16'd1) ||
                          (bus.row_i == 16'd0 && prev_row == coord_t'(IMAGE_HEIGHT - 1)))) begin
                        violation = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_col  <= '0;
            prev_row  <= '0;
            have_prev <= 1'b0;
            err_q     <= 1'b0;
        end else if (bus.valid_i) begin
            prev_col  <= bus.col_i;
            prev_row  <= bus.row_i;
            have_prev <= 1'b1;
            err_q     <= err_q | violation;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_downsampler_v_window_fp16.sv
// tb/tb_downsampler_v_window_fp16.sv - self-checking bench for the vertical downsampler
module tb_downsampler_v_window_fp16;
    import dfdd_pkg::*;

    localparam int     W   = 4;
    localparam int     H   = 4;
    localparam coord_t W16 = 16'd4;

    typedef logic [15:0] fp_t;
    typedef struct packed { logic v; fp_t w2; fp_t w1; fp_t w0; coord_t c; coord_t r; } exp_t;
    typedef struct packed { logic v; fp_t d; coord_t c; coord_t r; } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    downsampler_v_window_fp16_if #(.EXP_WIDTH(5), .FRAC_WIDTH(10)) bus ();

    downsampler_v_window_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference: the last two rows seen per column, plus a 2-deep expectation pipe.
    fp_t   m_prev1 [W];
    fp_t   m_prev2 [W];
    exp_t  e1, e2;
    beat_t q[$];
    logic [3*16+32-1:0] ref_seq[$];

    task automatic cycle(input logic v, input fp_t d, input coord_t c, input coord_t r);
        exp_t n;
        n = '0;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.col_i   = c;
        bus.row_i   = r;
        if (v && !rst && c < W16) begin
            n.v  = r[0];
            n.w0 = (r == 16'd1) ? m_prev1[c[1:0]] : m_prev2[c[1:0]];
            n.w1 = m_prev1[c[1:0]];
            n.w2 = d;
            n.c  = c;
            n.r  = r >> 1;
            m_prev2[c[1:0]] = m_prev1[c[1:0]];
            m_prev1[c[1:0]] = d;
        end
        if (rst) n = '0;
        e2 = e1;
        e1 = n;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0;
        e1 = '0;
        e2 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add_frame(input bit rand_data, input int gap_pct);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) < gap_pct) q.push_back('0);
                q.push_back({1'b1,
                             rand_data ? fp_t'($urandom) : fp_t'(16'h0100 * r + c),
                             coord_t'(c), coord_t'(r)});
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.window_o !== '0 || bus.col_o !== '0 ||
            bus.row_o !== '0 || bus.err_o !== 1'b0)
            $display("FAIL reset_state: got v=%b win=%h col=%0d row=%0d err=%b, expected all zero",
                     bus.valid_o, bus.window_o, bus.col_o, bus.row_o, bus.err_o);
        else passes++;
        checks++;
        if (bus.kernel_o !== 48'h3400_3800_3400)
            $display("FAIL kernel_in_reset: got %h expected 340038003400", bus.kernel_o);
        else passes++;
    endtask

    task automatic test_kernel();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, fp_t'($urandom), coord_t'($urandom), coord_t'($urandom));
            checks++;
            if (bus.kernel_o !== 48'h3400_3800_3400)
                $display("FAIL kernel: got %h expected 340038003400", bus.kernel_o);
            else passes++;
        end
    endtask

    task automatic test_frame();
        int vcount = 0;
        q.delete();
        ref_seq.delete();
        add_frame(1'b0, 0);
        for (int i = 0; i < 2; i++) q.push_back('0);
        foreach (q[i]) begin
            cycle(q[i].v, q[i].d, q[i].c, q[i].r);
            checks++;
            if (bus.valid_o !== e2.v || (e2.v && (bus.window_o !== {e2.w2, e2.w1, e2.w0} ||
                bus.col_o !== e2.c || bus.row_o !== e2.r)))
                $display("FAIL frame_out: got v=%b win=%h col=%0d row=%0d, expected v=%b win=%h col=%0d row=%0d",
                         bus.valid_o, bus.window_o, bus.col_o, bus.row_o, e2.v, {e2.w2, e2.w1, e2.w0}, e2.c, e2.r);
            else passes++;
            if (bus.valid_o === 1'b1) begin
                fp_t a, b, m;
                vcount++;
                ref_seq.push_back({bus.window_o, bus.col_o, bus.row_o});
                b = 16'h0100 * (2 * bus.row_o + 1) + bus.col_o;
                m = 16'h0100 * (2 * bus.row_o) + bus.col_o;
                a = (bus.row_o == 16'd0) ? m : fp_t'(16'h0100 * (2 * bus.row_o - 1) + bus.col_o);
                checks++;
                if (bus.window_o !== {b, m, a})
                    $display("FAIL frame_const: got %h expected %h", bus.window_o, {b, m, a});
                else passes++;
            end
        end
        checks++;
        if (vcount != 8) $display("FAIL frame_pulses: got %0d expected 8", vcount);
        else passes++;
        checks++;
        if (bus.err_o !== 1'b0) $display("FAIL frame_err: got %b expected 0", bus.err_o);
        else passes++;
    endtask

    task automatic test_latency();
        logic [2:0] seen;
        cycle(1'b1, 16'hABCD, 16'd2, 16'd3);
        seen[0] = bus.valid_o;
        cycle(1'b0, '0, '0, '0);
        seen[1] = bus.valid_o;
        checks++;
        if (bus.valid_o !== e2.v || bus.window_o !== {e2.w2, e2.w1, e2.w0} ||
            bus.col_o !== 16'd2 || bus.row_o !== 16'd1)
            $display("FAIL latency_data: got win=%h col=%0d row=%0d expected win=%h col=2 row=1",
                     bus.window_o, bus.col_o, bus.row_o, {e2.w2, e2.w1, e2.w0});
        else passes++;
        cycle(1'b0, '0, '0, '0);
        seen[2] = bus.valid_o;
        checks++;
        if (seen !== 3'b010) $display("FAIL latency_timing: got valid pattern %b expected 010", seen);
        else passes++;
    endtask

    task automatic test_random_gaps();
        int n = 0;
        q.delete();
        add_frame(1'b0, 50);
        for (int i = 0; i < 2; i++) q.push_back('0);
        foreach (q[i]) begin
            cycle(q[i].v, q[i].d, q[i].c, q[i].r);
            checks++;
            if (bus.valid_o !== e2.v || (e2.v && (bus.window_o !== {e2.w2, e2.w1, e2.w0} ||
                bus.col_o !== e2.c || bus.row_o !== e2.r)))
                $display("FAIL gaps_out: got v=%b win=%h col=%0d row=%0d, expected v=%b win=%h col=%0d row=%0d",
                         bus.valid_o, bus.window_o, bus.col_o, bus.row_o, e2.v, {e2.w2, e2.w1, e2.w0}, e2.c, e2.r);
            else passes++;
            if (bus.valid_o === 1'b1) begin
                checks++;
                if (n >= ref_seq.size() || {bus.window_o, bus.col_o, bus.row_o} !== ref_seq[n])
                    $display("FAIL gaps_seq: output %0d got %h differs from gapless sequence", n,
                             {bus.window_o, bus.col_o, bus.row_o});
                else passes++;
                n++;
            end
        end
        checks++;
        if (n != 8) $display("FAIL gaps_pulses: got %0d expected 8", n);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        q.delete();
        add_frame(1'b1, 0);
        foreach (q[i]) begin
            if (q[i].r == 16'd3 && q[i].c == 16'd1) break;
            cycle(q[i].v, q[i].d, q[i].c, q[i].r);
        end
        rst = 1'b1;
        e1 = '0;
        e2 = '0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.window_o !== '0 || bus.col_o !== '0 || bus.row_o !== '0)
            $display("FAIL midreset_clear: got v=%b win=%h col=%0d row=%0d expected zeros",
                     bus.valid_o, bus.window_o, bus.col_o, bus.row_o);
        else passes++;
        cycle(1'b1, 16'h5555, 16'd1, 16'd3);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, '0, '0);
            checks++;
            if (bus.valid_o !== 1'b0) $display("FAIL midreset_drop: got valid %b expected 0", bus.valid_o);
            else passes++;
        end
        q.delete();
        add_frame(1'b1, 0);
        for (int i = 0; i < 2; i++) q.push_back('0);
        foreach (q[i]) begin
            cycle(q[i].v, q[i].d, q[i].c, q[i].r);
            checks++;
            if (bus.valid_o !== e2.v || (e2.v && (bus.window_o !== {e2.w2, e2.w1, e2.w0} ||
                bus.col_o !== e2.c || bus.row_o !== e2.r)))
                $display("FAIL replay_out: got v=%b win=%h col=%0d row=%0d, expected v=%b win=%h col=%0d row=%0d",
                         bus.valid_o, bus.window_o, bus.col_o, bus.row_o, e2.v, {e2.w2, e2.w1, e2.w0}, e2.c, e2.r);
            else passes++;
        end
        checks++;
        if (bus.err_o !== 1'b0) $display("FAIL replay_err: got %b expected 0", bus.err_o);
        else passes++;
    endtask

    task automatic test_back_to_back();
        q.delete();
        add_frame(1'b1, 0);
        add_frame(1'b1, 0);
        for (int i = 0; i < 2; i++) q.push_back('0);
        foreach (q[i]) begin
            cycle(q[i].v, q[i].d, q[i].c, q[i].r);
            checks++;
            if (bus.valid_o !== e2.v || (e2.v && (bus.window_o !== {e2.w2, e2.w1, e2.w0} ||
                bus.col_o !== e2.c || bus.row_o !== e2.r)))
                $display("FAIL b2b_out: got v=%b win=%h col=%0d row=%0d, expected v=%b win=%h col=%0d row=%0d",
                         bus.valid_o, bus.window_o, bus.col_o, bus.row_o, e2.v, {e2.w2, e2.w1, e2.w0}, e2.c, e2.r);
            else passes++;
            if (i >= 2 * W * H && bus.valid_o === 1'b1 && e2.r == 16'd0) begin
                checks++;
                if (bus.window_o[0] !== e2.w1)
                    $display("FAIL b2b_top_repl: got above=%h expected %h", bus.window_o[0], e2.w1);
                else passes++;
            end
        end
        checks++;
        if (bus.err_o !== 1'b0) $display("FAIL b2b_err: got %b expected 0", bus.err_o);
        else passes++;
    endtask

    task automatic test_out_of_range();
        logic exp_err;
`ifdef DOWNSAMPLER_V_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        cycle(1'b1, 16'hDEAD, W16, 16'd3);
        checks++;
        if (bus.err_o !== exp_err) $display("FAIL oor_err_rise: got %b expected %b", bus.err_o, exp_err);
        else passes++;
        cycle(1'b1, 16'h7777, 16'd0, 16'd3);
        checks++;
        if (bus.valid_o !== 1'b0) $display("FAIL oor_no_valid: got %b expected 0", bus.valid_o);
        else passes++;
        cycle(1'b0, '0, '0, '0);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.window_o !== {e2.w2, e2.w1, e2.w0})
            $display("FAIL oor_no_write: got v=%b win=%h expected v=1 win=%h",
                     bus.valid_o, bus.window_o, {e2.w2, e2.w1, e2.w0});
        else passes++;
        repeat (3) cycle(1'b0, '0, '0, '0);
        checks++;
        if (bus.err_o !== exp_err) $display("FAIL oor_err_hold: got %b expected %b", bus.err_o, exp_err);
        else passes++;
        pulse_reset();
        checks++;
        if (bus.err_o !== 1'b0) $display("FAIL oor_err_clear: got %b expected 0", bus.err_o);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.col_i   = '0;
        bus.row_i   = '0;
        e1 = '0;
        e2 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_kernel();
        test_frame();
        pulse_reset();
        test_latency();
        pulse_reset();
        test_random_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        test_out_of_range();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
